// File: rtl/sram_axil_pkg.sv
// Shared types and response codes for the SRAM AXI-Lite slave.
package sram_axil_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_lat_cnt.sv
// 4-bit latency counter: load, saturating decrement, zero flag.
module axil_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_axil_slave.sv
// AXI-Lite slave fronting an internal word SRAM with independent read and
// write channels, programmable response latency and byte-strobed writes.
module sram_axil_slave
  import sram_axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------- read channel ----------------
  rd_state_t   r_state, r_next;
  logic        r_load, r_zero, r_enter, r_ok;
  logic [31:0] ar_addr_q, r_addr, r_off;

  // Read next-state and handshake outputs.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    r_load  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_load = 1'b1;
          r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
        end
      end
      R_WAIT: if (r_zero) r_next = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // With zero latency the response is taken in the handshake cycle, so use the live address.
  assign r_addr  = r_load ? araddr : ar_addr_q;
  assign r_off   = r_addr - BASE_ADDR;
  assign r_ok    = (r_off[31:AW+2] == '0);
  assign r_enter = (r_next == R_RESP) && (r_state != R_RESP);

  // Read state, address latch and response register (loaded once on response entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (r_load) ar_addr_q <= araddr;
      if (r_enter) begin
        rdata <= r_ok ? mem[r_off[AW+1:2]] : '0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axil_lat_cnt u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (r_load),
    .load_val (4'(RD_LAT)),
    .dec      (r_state == R_WAIT),
    .zero     (r_zero)
  );

  // ---------------- write channel ----------------
  wr_state_t   w_state, w_next;
  logic        aw_got, w_got, aw_hs, w_hs, w_load, w_zero, w_enter, w_ok;
  logic [31:0] aw_addr_q, w_data_q, w_addr, w_data, w_off;
  logic [3:0]  w_strb_q, w_strb;

  // Write next-state and handshake outputs; AW and W are accepted independently.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    w_load  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !aw_got;
        wready  = !w_got;
        if ((aw_got || awvalid) && (w_got || wvalid)) begin
          w_load = 1'b1;
          w_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
        end
      end
      W_WAIT: if (w_zero) w_next = W_RESP;
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  // Bypass the capture registers when the commit coincides with the last handshake.
  assign w_addr  = aw_hs ? awaddr : aw_addr_q;
  assign w_data  = w_hs ? wdata : w_data_q;
  assign w_strb  = w_hs ? wstrb : w_strb_q;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_ok    = (w_off[31:AW+2] == '0);
  assign w_enter = (w_next == W_RESP) && (w_state != W_RESP);

  // Write state, capture flags/registers and response code.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (w_load) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (w_enter) bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Byte-masked memory commit on write-response entry; not reset, and an aborting reset suppresses it.
  always_ff @(posedge clk) begin
    if (w_enter && w_ok && !rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[w_off[AW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  axil_lat_cnt u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (4'(WR_LAT)),
    .dec      (w_state == W_WAIT),
    .zero     (w_zero)
  );

  // Byte-offset bits do not select a word.
  logic unused_byte_off;
  assign unused_byte_off = ^{r_off[1:0], w_off[1:0]};

endmodule
